// File: rtl/wb_stage.sv
// Writeback stage: merges load responses and ALU results into the single register-file write port.
// Loads always win; ALU results that lose arbitration wait in a small in-order FIFO.
module wb_stage #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  input  logic [XLEN-1:0] ld_raw,
  output logic [4:0]      w_reg,
  output logic [XLEN-1:0] w_data,
  output logic            w_en,
  output logic [31:0]     pend_rd_mask
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]      r_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_data [FIFO_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_acc;
  logic            w_push;
  logic            w_pop;
  logic            w_sel_valid;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ld_fmt;

  assign alu_ready = !rst && (r_count < CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_acc     = alu_valid && alu_ready;

  // Shift amount is the byte offset aligned down to the access size.
  always_comb begin
    w_shamt = 6'd0;
    unique case (ld_funct3[1:0])
      2'b00:   w_shamt = {ld_offset, 3'b000};
      2'b01:   w_shamt = {ld_offset[2:1], 4'b0000};
      2'b10:   w_shamt = {ld_offset[2], 5'b00000};
      default: w_shamt = 6'd0;
    endcase
  end

  assign w_shifted = ld_raw >> w_shamt;

  always_comb begin
    w_ld_fmt = w_shifted;
    unique case (ld_funct3)
      3'b000:  w_ld_fmt = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_ld_fmt = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      3'b010:  w_ld_fmt = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b110:  w_ld_fmt = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: w_ld_fmt = ld_raw;
    endcase
  end

  // Priority: load, then FIFO head, then ALU bypass (only when nothing else is pending).
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = '0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (ld_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = ld_rd;
      w_sel_data  = w_ld_fmt;
      w_push      = w_acc;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_rd[r_head];
      w_sel_data  = r_data[r_head];
      w_pop       = 1'b1;
      w_push      = w_acc;
    end else if (w_acc) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      w_en    <= 1'b0;
      w_reg   <= 5'd0;
      w_data  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // x0 writes are consumed silently; the port keeps its last index and data.
      w_en <= w_sel_valid && (w_sel_rd != 5'd0);
      if (w_sel_valid && (w_sel_rd != 5'd0)) begin
        w_reg  <= w_sel_rd;
        w_data <= w_sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= alu_rd;
      r_data[r_tail] <= alu_data;
    end
  end

  always_comb begin
    pend_rd_mask = 32'd0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CW'(i) < r_count) begin
        pend_rd_mask[r_rd[r_head + PW'(i)]] = 1'b1;
      end
    end
    pend_rd_mask[0] = 1'b0;
  end

endmodule
